// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, counter width and RGB field layout
// shared by vga_ctrl and vga_timing_cnt.
// Optional feature macro used by vga_ctrl: VGA_FRAME_CNT_EN.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_H_END   = DEF_H_START + DEF_H_ACTIVE;
  localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_V_END   = DEF_V_START + DEF_V_ACTIVE;

  // pixel word layout {B,G,R}, 4 bits per colour
  localparam int RGB_W = 4;
  localparam int R_LSB = 0;
  localparam int G_LSB = 4;
  localparam int B_LSB = 8;

endpackage

// File: rtl/vga_timing_cnt.sv
// vga_timing_cnt: free-running horizontal/vertical raster counters.
// line_end marks the last pixel clock of a line, frame_end the last of a frame.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  // advance the raster position; both counters wrap together at frame end
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign h_cnt     = r_h_cnt;
  assign v_cnt     = r_v_cnt;
  assign line_end  = w_line_end;
  assign frame_end = w_frame_end;

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing controller. Requests pixels one cycle ahead of the
// active window, registers sync and blanked RGB so the panel sees them aligned.
// Optional feature macro: VGA_FRAME_CNT_EN adds frame_cnt and frame_start.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  input  logic [11:0]      pixel_data,
  output logic             data_req,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
`ifdef VGA_FRAME_CNT_EN
  output logic [3:0]       vga_b,
  output logic [7:0]       frame_cnt,
  output logic             frame_start
`else
  output logic [3:0]       vga_b
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  // request window leads the active window by one pixel clock
  localparam logic [CNT_W-1:0] H_REQ_S_C = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_REQ_E_C = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_line_end;
  logic             w_frame_end;
  logic             w_v_in;
  logic             w_req;
  logic             w_active;

  logic             r_hsync;
  logic             r_vsync;
  logic [11:0]      r_rgb;

  vga_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing_cnt (
    .vga_clk   (vga_clk),
    .vga_rst   (vga_rst),
    .h_cnt     (w_h_cnt),
    .v_cnt     (w_v_cnt),
    .line_end  (w_line_end),
    .frame_end (w_frame_end)
  );

  // decode request and active windows from the current raster position
  always_comb begin
    w_v_in   = (w_v_cnt >= V_START_C) && (w_v_cnt < V_END_C);
    w_req    = (w_h_cnt >= H_REQ_S_C) && (w_h_cnt < H_REQ_E_C) && w_v_in;
    w_active = (w_h_cnt >= H_START_C) && (w_h_cnt < H_END_C) && w_v_in;
  end

  assign data_req = w_req;
  assign x_pos    = w_req ? (w_h_cnt - H_REQ_S_C) : '0;
  assign y_pos    = w_req ? (w_v_cnt - V_START_C) : '0;

  // register sync and blanked pixel on the same edge to keep them aligned
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_hsync <= !(w_h_cnt < H_SYNC_C);
      r_vsync <= !(w_v_cnt < V_SYNC_C);
      r_rgb   <= w_active ? pixel_data : 12'h000;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign vga_r = r_rgb[R_LSB +: RGB_W];
  assign vga_g = r_rgb[G_LSB +: RGB_W];
  assign vga_b = r_rgb[B_LSB +: RGB_W];

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;
  logic       r_frame_start;

  // count completed frames and flag the first cycle of each new frame
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign frame_cnt   = r_frame_cnt;
  assign frame_start = r_frame_start;

  logic w_unused_ends;
  assign w_unused_ends = w_line_end;
`else
  // wrap strobes are only consumed by the frame counter
  logic w_unused_ends;
  assign w_unused_ends = w_line_end ^ w_frame_end;
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: self-checking bench for vga_ctrl. A reduced-geometry instance
// is checked cycle by cycle against a position-based reference model; a
// default-geometry instance is checked for 640x480 line timing and bounds.
module tb_vga_ctrl;

  // reduced geometry: line 17 clocks, frame 10 lines
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int HST = HS + HB, HEN = HS + HB + HA;
  localparam int VST = VS + VB, VEN = VS + VB + VA;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst;
  logic [11:0] stim;
  logic        gen_mode;
  logic [11:0] gen_reg;
  logic [11:0] pixel_data;
  logic        data_req, hsync, vsync;
  logic [9:0]  x_pos, y_pos;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frame_cnt, frame_cnt_d;
  logic        frame_start, frame_start_d;
`endif

  assign pixel_data = gen_mode ? gen_reg : stim;

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .vga_clk(clk), .vga_rst(rst), .pixel_data(pixel_data),
    .data_req(data_req), .x_pos(x_pos), .y_pos(y_pos),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g),
`ifdef VGA_FRAME_CNT_EN
    .vga_b(vga_b), .frame_cnt(frame_cnt), .frame_start(frame_start)
`else
    .vga_b(vga_b)
`endif
  );

  // default 640x480 instance
  logic        rst_d;
  logic [11:0] pd_d;
  logic        req_d, hs_d, vs_d;
  logic [9:0]  x_d, y_d;
  logic [3:0]  r_d, g_d, b_d;

  vga_ctrl dut_def (
    .vga_clk(clk), .vga_rst(rst_d), .pixel_data(pd_d),
    .data_req(req_d), .x_pos(x_d), .y_pos(y_d),
    .hsync(hs_d), .vsync(vs_d),
    .vga_r(r_d), .vga_g(g_d),
`ifdef VGA_FRAME_CNT_EN
    .vga_b(b_d), .frame_cnt(frame_cnt_d), .frame_start(frame_start_d)
`else
    .vga_b(b_d)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // registered test-pattern generator: {x, y, 0} one cycle after the request
  always @(posedge clk) gen_reg <= {x_pos[3:0], y_pos[3:0], 4'b0000};

  // ---------------- reference model (raster position as one integer) -------
  int          m_pos   = 0;
  logic        m_valid = 1'b0;
  logic        e_hs, e_vs;
  logic [11:0] e_rgb;
  logic [7:0]  e_fc;
  logic        e_fs;

  function automatic bit in_req(input int p);
    int h = p % HT;
    int v = p / HT;
    return (h >= HST - 1) && (h < HEN - 1) && (v >= VST) && (v < VEN);
  endfunction

  function automatic bit in_act(input int p);
    int h = p % HT;
    int v = p / HT;
    return (h >= HST) && (h < HEN) && (v >= VST) && (v < VEN);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pos   <= 0;
      m_valid <= 1'b1;
      e_hs    <= 1'b1;
      e_vs    <= 1'b1;
      e_rgb   <= 12'h000;
      e_fc    <= 8'd0;
      e_fs    <= 1'b0;
    end else begin
      e_hs  <= (m_pos % HT) >= HS;
      e_vs  <= (m_pos / HT) >= VS;
      e_rgb <= in_act(m_pos) ? pixel_data : 12'h000;
      e_fs  <= (m_pos == FT - 1);
      if (m_pos == FT - 1) e_fc <= e_fc + 8'd1;
      m_pos <= (m_pos + 1) % FT;
    end
  end

  // continuous comparison of the reduced instance against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("mdl_req", data_req, in_req(m_pos));
      check("mdl_x", x_pos, in_req(m_pos) ? (m_pos % HT) - (HST - 1) : 0);
      check("mdl_y", y_pos, in_req(m_pos) ? (m_pos / HT) - VST : 0);
      check("mdl_hsync", hsync, e_hs);
      check("mdl_vsync", vsync, e_vs);
      check("mdl_rgb", {vga_b, vga_g, vga_r}, e_rgb);
`ifdef VGA_FRAME_CNT_EN
      check("mdl_frame_cnt", frame_cnt, e_fc);
      check("mdl_frame_start", frame_start, e_fs);
`endif
    end
  end

  // ---------------- vector table: raster position -> decoded outputs -------
  typedef struct {
    int         h;
    int         v;
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs_next;
    logic       vs_next;
  } vec_t;

  vec_t vecs[10];

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int req_cnt, on_cnt;
    int first_low, first_high, second_low, first_req, run, last_req_k, xy_bad;
    logic [9:0] fx, fy, last_x;
    logic prev_hs;

    vecs[0] = '{0,  0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    vecs[1] = '{3,  0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    vecs[2] = '{0,  1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    vecs[3] = '{6,  4, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};
    vecs[4] = '{13, 8, 1'b1, 10'd7, 10'd4, 1'b1, 1'b1};
    vecs[5] = '{14, 8, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
    vecs[6] = '{5,  4, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
    vecs[7] = '{6,  9, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
    vecs[8] = '{6,  3, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
    vecs[9] = '{10, 6, 1'b1, 10'd4, 10'd2, 1'b1, 1'b1};

    gen_mode = 1'b0;
    stim     = 12'h000;
    pd_d     = 12'hFFF;
    rst_d    = 1'b1;
    rst      = 1'b1;

    // reset held 3 cycles: outputs idle
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
      check("rst_rgb", {vga_b, vga_g, vga_r}, 12'h000);
      check("rst_req", data_req, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_hsync_low", hsync, 1'b0);
    $display("reset release: hsync=%0b one cycle after release", hsync);

    // table-driven position vectors
    for (int i = 0; i < 10; i++) begin
      reset_dut(1);
      repeat (vecs[i].v * HT + vecs[i].h) @(posedge clk);
      @(negedge clk);
      check("vec_req", data_req, vecs[i].req);
      check("vec_x", x_pos, vecs[i].x);
      check("vec_y", y_pos, vecs[i].y);
      @(posedge clk);
      @(negedge clk);
      check("vec_hsync", hsync, vecs[i].hs_next);
      check("vec_vsync", vsync, vecs[i].vs_next);
      $display("vec %0d h=%0d v=%0d req=%0b x=%0d y=%0d hs=%0b vs=%0b",
               i, vecs[i].h, vecs[i].v, vecs[i].req, vecs[i].x, vecs[i].y, hsync, vsync);
    end

    // constant white: lit only inside the window, request count matches
    reset_dut(1);
    stim    = 12'hFFF;
    req_cnt = 0;
    on_cnt  = 0;
    for (int k = 0; k <= FT; k++) begin
      if (k < FT && data_req) req_cnt++;
      if (k > 0 && {vga_b, vga_g, vga_r} == 12'hFFF) on_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    check("white_req_cycles", req_cnt, HA * VA);
    check("white_lit_cycles", on_cnt, HA * VA);
    $display("white frame: req=%0d lit=%0d", req_cnt, on_cnt);

    // random pixel data over two frames, model compares every cycle
    reset_dut(1);
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      stim = 12'($urandom);
    end
    $display("random frames: two frames of random pixel_data applied");

    // registered generator alignment: first active output is x=0, next x=1
    gen_mode = 1'b1;
    reset_dut(1);
    repeat (VST * HT + HST + 1) @(posedge clk);
    @(negedge clk);
    check("gen_first_rgb", {vga_b, vga_g, vga_r}, 12'h000);
    @(posedge clk);
    @(negedge clk);
    check("gen_second_b", vga_b, 4'd1);
    check("gen_second_gr", {vga_g, vga_r}, 8'h00);
    $display("generator: second active output b=%0d g=%0d r=%0d", vga_b, vga_g, vga_r);
    gen_mode = 1'b0;

    // reset mid-frame, then restart with a sync pulse
    reset_dut(1);
    repeat (6 * HT + 10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_hsync", hsync, 1'b1);
    check("midrst_req", data_req, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_hsync_low", hsync, 1'b0);
    check("midrst_vsync_low", vsync, 1'b0);
`ifdef VGA_FRAME_CNT_EN
    check("midrst_frame_cnt0", frame_cnt, 8'd0);
    repeat (2 * FT - 1) @(posedge clk);
    @(negedge clk);
    check("midrst_frame_cnt2", frame_cnt, 8'd2);
    check("midrst_frame_start", frame_start, 1'b1);
`endif
    $display("mid-frame reset: hsync=%0b vsync=%0b after release", hsync, vsync);

    // default 640x480 geometry: line timing and first active line bounds
    rst_d = 1'b0;
    first_low = -1; first_high = -1; second_low = -1;
    first_req = -1; run = 0; last_req_k = -1; xy_bad = 0;
    fx = '0; fy = '0; last_x = '0;
    prev_hs = 1'b1;
    for (int k = 0; k < 28800; k++) begin
      if (prev_hs && !hs_d) begin
        if (first_low < 0) first_low = k;
        else if (second_low < 0) second_low = k;
      end
      if (!prev_hs && hs_d && first_low >= 0 && first_high < 0) first_high = k;
      if (!req_d && (x_d != 0 || y_d != 0)) xy_bad++;
      if (req_d) begin
        if (first_req < 0) begin
          first_req = k;
          fx = x_d;
          fy = y_d;
        end
        if (k < first_req + 800) begin
          run++;
          last_x = x_d;
          last_req_k = k;
        end
      end
      prev_hs = hs_d;
      @(posedge clk);
      @(negedge clk);
    end
    check("def_hsync_first_low", first_low, 1);
    check("def_hsync_width", first_high - first_low, 96);
    check("def_hsync_period", second_low - first_low, 800);
    check("def_first_req_cycle", first_req, 35 * 800 + 143);
    check("def_first_x", fx, 10'd0);
    check("def_first_y", fy, 10'd0);
    check("def_req_run", run, 640);
    check("def_req_contiguous", last_req_k - first_req, 639);
    check("def_last_x", last_x, 10'd639);
    check("def_xy_zero_idle", xy_bad, 0);
    $display("default timing: hs_low=%0d width=%0d period=%0d first_req=%0d run=%0d last_x=%0d",
             first_low, first_high - first_low, second_low - first_low, first_req, run, last_x);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
Timing controller directly upstream and downstream of the test-pattern pixel generator. Runs the 640x480@60 raster counters and drives hsync/vsync. Issues a data request with x_pos/y_pos one cycle ahead of active video. Captures the generator's registered pixel_data and drives the panel RGB pins, blanked outside the active window.

Parameters:
H_SYNC, 96, hsync pulse width in pixel clocks
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch

Ports:
vga_clk  in  1  pixel clock, 25 MHz
vga_rst  in  1  synchronous active-high reset
pixel_data  in  12  pixel from generator, {B[3:0],G[3:0],R[3:0]}, valid 1 cycle after data_req
data_req  out  1  high when x_pos/y_pos request a pixel
x_pos  out  10  requested column 0..H_ACTIVE-1, 0 when data_req low
y_pos  out  10  requested row 0..V_ACTIVE-1, 0 when data_req low
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
vga_r  out  4  red, from pixel_data[3:0]
vga_g  out  4  green, from pixel_data[7:4]
vga_b  out  4  blue, from pixel_data[11:8]

Behaviour:
- Clock and reset: one clock, vga_clk. vga_rst is synchronous and active-high.
- Reset values: h_cnt=0, v_cnt=0, hsync=1, vsync=1, vga_r/g/b=0, data_req=0, x_pos=0, y_pos=0 while vga_rst=1.
- Horizontal counter: h_cnt counts 0..H_TOTAL-1, with H_TOTAL = sum of the four H parameters = 800. It wraps to 0.
- Vertical counter: v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, with V_TOTAL = 525. It wraps to 0 on the same edge as h_cnt when both are at their maximum.
- Sync region: the line starts with sync, then back porch, active, front porch.
- Active window:
  - H_START = H_SYNC+H_BACK = 144, H_END = H_START+H_ACTIVE = 784.
  - V_START = V_SYNC+V_BACK = 35, V_END = 515.
- Request window:
  - data_req is combinational: (h_cnt in [H_START-1, H_END-1)) AND (v_cnt in [V_START, V_END)).
  - x_pos = h_cnt-(H_START-1) and y_pos = v_cnt-V_START while data_req is high; both are 0 otherwise.
- Generator latency: the generator registers pixel_data one cycle after the request. pixel_data sampled while h_cnt=H_START therefore belongs to x=0.
- Registered outputs, all updated on the same edge:
  - hsync <= !(h_cnt < H_SYNC)
  - vsync <= !(v_cnt < V_SYNC)
  - active = h_cnt in [H_START,H_END) AND v_cnt in [V_START,V_END)
  - {vga_b,vga_g,vga_r} <= active ? pixel_data : 0
  - The panel therefore sees sync and RGB uniformly delayed 1 cycle from the counters, and stays aligned.
- Blanking: RGB is 0 in every non-active cycle regardless of pixel_data.
- Reset mid-frame: counters return to 0 on the next edge, and the frame restarts with a sync pulse. No partial-line recovery.
- Arithmetic: counters are 10 bits and unsigned. Subtractions producing x_pos/y_pos never underflow, because they are evaluated only inside the window.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: adds output frame_cnt [7:0].
  - Resets to 0.
  - Increments on the edge where h_cnt and v_cnt both wrap to 0.
  - Wraps 255->0.
  - Also adds output frame_start [1], a 1-cycle pulse on the cycle after that wrap (h_cnt=0, v_cnt=0 first cycle).
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package vga_pkg:
  - default timing constants and derived H_TOTAL, V_TOTAL, H_START, H_END, V_START, V_END
  - counter width localparam (10)
  - RGB field offsets (R=[3:0], G=[7:4], B=[11:8])
- Sub-module vga_timing_cnt:
  - is the natural split
  - holds the h/v counters and the wrap logic
  - exports h_cnt, v_cnt, line_end, frame_end
- vga_ctrl holds the decode and the output registers.

Test Plan:
- Hold vga_rst 3 cycles, then release: during reset hsync=vsync=1, rgb=0, data_req=0. First hsync low appears 1 cycle after release.
- Horizontal timing: over 2 lines, measure hsync period=800 cycles, low width=96. data_req is high for exactly 640 consecutive cycles per active line.
- Vertical timing: over 2 frames, vsync period=420000 cycles, low width=1600 cycles. data_req lines per frame=480.
- Bounds:
  - first data_req at v_cnt=35, h_cnt=143 has x_pos=0, y_pos=0
  - last data_req has x_pos=639, y_pos=479
  - x_pos=y_pos=0 whenever data_req=0
- Alignment and blanking:
  - pixel_data driven to 0xFFF constantly: rgb=0xF/0xF/0xF only in the 640x480 window and 0 in every blanking cycle
  - pixel_data = {x_pos[3:0],y_pos[3:0],4'b0} from a registered model: rgb at first active output cycle = 0/0/0, next = b=1
- Pulse vga_rst mid-line (h_cnt=400, v_cnt=200):
  - counters restart at 0
  - next hsync low begins 1 cycle after release
  - with VGA_FRAME_CNT_EN, frame_cnt returns to 0 and reaches 2 after 2 full frames
